sys_array_feeder: RTL and testbench

Source side of the N×N systolic array. The block buffers an A matrix and a B matrix and, on `start`, clears the array accumulators. It then streams A rows into the west edge and B columns into the north edge with the diagonal skew the PE grid requires, so that PE(i,j) ends holding the dot product of row i of A with column j of B. It is the transmitter for the PE `inp_w`/`inp_n` edge inputs and the PE `rst` clear.

---
 rtl/sys_array_pkg.sv | 21 ++
 rtl/sys_array_feeder.sv | 138 +++++++++++++
 tb/tb_sys_array_feeder.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_array_pkg.sv
// rtl/sys_array_pkg.sv - shared types and constants for the systolic array and its feeder
package sys_array_pkg;

    // Default array geometry, shared with the PE grid top
    localparam int SA_N  = 4;
    localparam int SA_DW = 32;

    // Feeder run phases
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } feeder_state_t;

    // LSB position of lane 'lane' in a packed bus of dw-bit lanes
    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/sys_array_feeder.sv
// rtl/sys_array_feeder.sv - buffers A/B matrices and streams them skewed into the PE array edges
module sys_array_feeder
    import sys_array_pkg::*;
#(
    parameter int N  = SA_N,
    parameter int DW = SA_DW,
    parameter int AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_row,
    input  logic [AW-1:0]   wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            arr_rst,
    output logic [N*DW-1:0] west_out,
    output logic [N*DW-1:0] north_out
);

    // Step counter is reused for the stream (0..2N-2) and drain (0..N-1) phases
    localparam int            CW            = $clog2(2 * N);
    localparam logic [CW-1:0] T_STREAM_LAST = CW'(2 * N - 2);
    localparam logic [CW-1:0] T_DRAIN_LAST  = CW'(N - 1);

    logic [DW-1:0] r_a [N][N];
    logic [DW-1:0] r_b [N][N];

    feeder_state_t r_state;
    feeder_state_t w_state_next;
    logic [CW-1:0] r_t;
    logic [CW-1:0] w_t_next;

    logic            w_wr_ok;
    logic [N*DW-1:0] w_west_next;
    logic [N*DW-1:0] w_north_next;

    // Writes land only while idle and only for in-range indices
    assign w_wr_ok = wr_en && (r_state == ST_IDLE)
                     && (32'(wr_row) < N) && (32'(wr_col) < N);

    // Matrix storage, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_a[i][j] <= '0;
                    r_b[i][j] <= '0;
                end
            end
        end else if (w_wr_ok) begin
            if (wr_sel) begin
                r_b[wr_row][wr_col] <= wr_data;
            end else begin
                r_a[wr_row][wr_col] <= wr_data;
            end
        end
    end

    // State and step counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
        end else begin
            r_state <= w_state_next;
            r_t     <= w_t_next;
        end
    end

    // Next-state and step counter sequencing
    always_comb begin
        w_state_next = r_state;
        w_t_next     = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (r_t == T_STREAM_LAST) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_t_next = r_t + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_t == T_DRAIN_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_t_next = r_t + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Diagonal skew: lane i carries element k = t - i of its row/column while 0 <= k < N.
    // West lane i and north lane j use the same window, so one compare serves both.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [CW-1:0] w_k;
        logic          w_live;

        assign w_k    = w_t_next - CW'(gi);
        assign w_live = (w_state_next == ST_STREAM)
                        && (w_t_next >= CW'(gi)) && (w_k < CW'(N));

        assign w_west_next[lane_lsb(gi, DW) +: DW]  = w_live ? r_a[gi][w_k[AW-1:0]] : '0;
        assign w_north_next[lane_lsb(gi, DW) +: DW] = w_live ? r_b[w_k[AW-1:0]][gi] : '0;
    end

    // Registered outputs decoded from the upcoming state so they align with the phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            arr_rst   <= 1'b0;
            west_out  <= '0;
            north_out <= '0;
        end else begin
            busy      <= (w_state_next != ST_IDLE);
            done      <= (r_state == ST_DRAIN) && (w_state_next == ST_IDLE);
            arr_rst   <= (w_state_next == ST_CLEAR);
            west_out  <= w_west_next;
            north_out <= w_north_next;
        end
    end

endmodule

// File: tb/tb_sys_array_feeder.sv
// tb/tb_sys_array_feeder.sv - randomized self-checking bench with reference model and PE grid harness
module tb_sys_array_feeder;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int W  = N * DW;

    logic           clk;
    logic           rst;
    logic           wr_en;
    logic           wr_sel;
    logic [1:0]     wr_row;
    logic [1:0]     wr_col;
    logic [DW-1:0]  wr_data;
    logic           start;
    logic           busy;
    logic           done;
    logic           arr_rst;
    logic [W-1:0]   west_out;
    logic [W-1:0]   north_out;

    int n_checks = 0;
    int n_pass   = 0;

    sys_array_feeder #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .arr_rst   (arr_rst),
        .west_out  (west_out),
        .north_out (north_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: run age counts cycles since start (0 = idle, 1 = clear, 3N = last drain)
    int            m_age;
    logic          m_done;
    logic [DW-1:0] m_a [N][N];
    logic [DW-1:0] m_b [N][N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_age  <= 0;
            m_done <= 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    m_a[i][j] <= '0;
                    m_b[i][j] <= '0;
                end
        end else begin
            m_done <= (m_age == 3 * N);
            if (m_age == 0) begin
                if (wr_en) begin
                    if (wr_sel) m_b[wr_row][wr_col] <= wr_data;
                    else        m_a[wr_row][wr_col] <= wr_data;
                end
                if (start) m_age <= 1;
            end else if (m_age == 3 * N) begin
                m_age <= 0;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    // Expected edge bus: during stream step t lane i carries element t-i of its row/column
    function automatic logic [W-1:0] exp_lanes(input bit north);
        logic [W-1:0] v;
        int t;
        int k;
        v = '0;
        if (m_age >= 2 && m_age <= 2 * N) begin
            t = m_age - 2;
            for (int i = 0; i < N; i++) begin
                k = t - i;
                if (k >= 0 && k < N) v[i*DW +: DW] = north ? m_b[k][i] : m_a[i][k];
            end
        end
        return v;
    endfunction

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("busy",    W'(busy),    W'(m_age != 0));
            check("done",    W'(done),    W'(m_done));
            check("arr_rst", W'(arr_rst), W'(m_age == 1));
            check("west",    west_out,    exp_lanes(1'b0));
            check("north",   north_out,   exp_lanes(1'b1));
        end
    end

    // Behavioural PE grid fed by the DUT edges
    logic [63:0]   pe_acc [N][N];
    logic [DW-1:0] pe_w   [N][N];
    logic [DW-1:0] pe_n   [N][N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pe_acc[i][j] <= '0;
                    pe_w[i][j]   <= '0;
                    pe_n[i][j]   <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    logic [DW-1:0] wi;
                    logic [DW-1:0] ni;
                    if (j == 0) wi = west_out[i*DW +: DW];
                    else        wi = pe_w[i][j-1];
                    if (i == 0) ni = north_out[j*DW +: DW];
                    else        ni = pe_n[i-1][j];
                    if (arr_rst) pe_acc[i][j] <= '0;
                    else         pe_acc[i][j] <= pe_acc[i][j] + 64'(wi) * 64'(ni);
                    pe_w[i][j] <= wi;
                    pe_n[i][j] <= ni;
                end
        end
    end

    function automatic logic [W-1:0] rep(input logic [3:0] mask, input logic [DW-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (mask[i]) r[i*DW +: DW] = v;
        return r;
    endfunction

    task automatic wr(input bit sel, input int r, input int c, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = 2'(r);
        wr_col  = 2'(c);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_random(input int maxv);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r, c, $urandom_range(maxv));
                wr(1'b1, r, c, $urandom_range(maxv));
            end
    endtask

    task automatic wait_done(output int busy_cycles);
        bit seen;
        seen = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (busy) busy_cycles++;
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check("done_timeout", W'(0), W'(1));
    endtask

    task automatic run_wait(output int busy_cycles);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(busy_cycles);
    endtask

    task automatic check_results();
        logic [63:0] e;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                e = '0;
                for (int k = 0; k < N; k++) e = e + 64'(m_a[i][k]) * 64'(m_b[k][j]);
                check($sformatf("pe_%0d_%0d", i, j), W'(pe_acc[i][j]), W'(e));
            end
    endtask

    initial begin
        int bc;
        int dcount;
        logic [63:0] p00;

        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
        wr_data = '0; start = 1'b0;
        @(negedge clk);
        check("rst_busy",  W'(busy),    W'(0));
        check("rst_done",  W'(done),    W'(0));
        check("rst_arr",   W'(arr_rst), W'(0));
        check("rst_west",  west_out,    W'(0));
        check("rst_north", north_out,   W'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Identity A times B[r][c] = 4r+c
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r, c, (r == c) ? 32'd1 : 32'd0);
                wr(1'b1, r, c, 32'(4 * r + c));
            end
        run_wait(bc);
        check("busy_cycles", W'(bc), W'(12));
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("ident_%0d_%0d", i, j), W'(pe_acc[i][j]), W'(4 * i + j));
        @(negedge clk);
        check("done_single", W'(done), W'(0));

        // All-2s lane probe
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r, c, 32'd2);
                wr(1'b1, r, c, 32'd2);
            end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int a = 1; a <= 3 * N; a++) begin
            case (a)
                2: begin
                    check("t0_west",  west_out,  rep(4'b0001, 32'd2));
                    check("t0_north", north_out, rep(4'b0001, 32'd2));
                end
                5: begin
                    check("t3_west",  west_out,  rep(4'b1111, 32'd2));
                    check("t3_north", north_out, rep(4'b1111, 32'd2));
                end
                8: begin
                    check("t6_west",  west_out,  rep(4'b1000, 32'd2));
                    check("t6_north", north_out, rep(4'b1000, 32'd2));
                end
                9: begin
                    check("drain_west",  west_out,  W'(0));
                    check("drain_north", north_out, W'(0));
                end
                default: ;
            endcase
            @(negedge clk);
        end
        check("twos_done", W'(done), W'(1));
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("twos_%0d_%0d", i, j), W'(pe_acc[i][j]), W'(16));

        // start and wr_en during STREAM are ignored
        load_random(255);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 32'd99;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        wait_done(bc);
        check_results();
        p00 = pe_acc[0][0];
        @(negedge clk);
        check("no_queued_start", W'(busy), W'(0));
        run_wait(bc);
        check("a00_kept", W'(pe_acc[0][0]), W'(p00));
        check_results();

        // Asynchronous reset at STREAM t=2
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r, c, 32'd1);
                wr(1'b1, r, c, 32'd1);
            end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",  W'(busy),    W'(0));
        check("arst_done",  W'(done),    W'(0));
        check("arst_arr",   W'(arr_rst), W'(0));
        check("arst_west",  west_out,    W'(0));
        check("arst_north", north_out,   W'(0));
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("arst_no_done", W'(dcount), W'(0));
        wr(1'b0, 0, 0, 32'd3);
        wr(1'b1, 0, 1, 32'd5);
        run_wait(bc);
        check("arst_pe01", W'(pe_acc[0][1]), W'(15));
        check("arst_pe00", W'(pe_acc[0][0]), W'(0));
        check("arst_pe11", W'(pe_acc[1][1]), W'(0));
        check_results();

        // Random full-range runs
        for (int n = 0; n < 2; n++) begin
            load_random(32'hFFFF_FFFF);
            run_wait(bc);
            check("rand_busy_cycles", W'(bc), W'(12));
            check_results();
        end

        // Back-to-back: start in the done cycle with a new B element
        load_random(1000);
        run_wait(bc);
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_row = 2'd1; wr_col = 2'd2; wr_data = 32'd777;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        check("b2b_arr_rst", W'(arr_rst), W'(1));
        check("b2b_b12", W'(m_b[1][2]), W'(777));
        wait_done(bc);
        check_results();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
